// File: rtl/datapath_controller.sv
// datapath_controller: sequences a nibble-matching datapath. Each job loads
// the cypher, then for NUM_KEYS compared nibbles scans all four cypher
// nibbles, accumulating the compared value into sum on every match, and
// finally writes sum_out and pulses done.
module datapath_controller #(
  parameter int NUM_KEYS = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic compared_valid,
  output logic compared_ready,
  input  logic stop,
  input  logic equal,
  output logic sl_sum,
  output logic sl_index,
  output logic wr_cypher,
  output logic wr_compared,
  output logic wr_sum,
  output logic wr_index,
  output logic wr_sum_out,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_KEY,
    SCAN,
    WRITE,
    DONE
  } state_t;

  localparam logic [1:0] LAST_KEY = 2'(NUM_KEYS - 1);

  state_t     state;
  state_t     state_next;
  logic [1:0] key_count;
  logic [1:0] key_count_next;

  // State and key counter registers; reset abandons any job in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      key_count <= 2'd0;
    end else begin
      state     <= state_next;
      key_count <= key_count_next;
    end
  end

  // Next-state logic and datapath strobes; SCAN strobes are Mealy on stop/equal.
  always_comb begin
    state_next     = state;
    key_count_next = key_count;
    compared_ready = 1'b0;
    sl_sum         = 1'b0;
    sl_index       = 1'b0;
    wr_cypher      = 1'b0;
    wr_compared    = 1'b0;
    wr_sum         = 1'b0;
    wr_index       = 1'b0;
    wr_sum_out     = 1'b0;
    done           = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        wr_cypher      = 1'b1;
        wr_sum         = 1'b1;
        wr_index       = 1'b1;
        key_count_next = 2'd0;
        state_next     = WAIT_KEY;
      end
      WAIT_KEY: begin
        compared_ready = 1'b1;
        if (compared_valid) begin
          wr_compared = 1'b1;
          wr_index    = 1'b1;
          state_next  = SCAN;
        end
      end
      SCAN: begin
        if (!stop) begin
          wr_index = 1'b1;
          sl_index = 1'b1;
          sl_sum   = 1'b1;
          wr_sum   = equal;
        end else if (key_count == LAST_KEY) begin
          state_next = WRITE;
        end else begin
          key_count_next = key_count + 2'd1;
          state_next     = WAIT_KEY;
        end
      end
      WRITE: begin
        wr_sum_out = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_datapath_controller.sv
// tb_datapath_controller: three controllers (NUM_KEYS = 1, 2, 4), each wired
// to a small behavioural datapath, driven by directed vectors whose expected
// control patterns and sums were worked out by hand.
module tb_datapath_controller;

  // Control vector bit order:
  // {compared_ready, busy, done, sl_sum, sl_index,
  //  wr_cypher, wr_compared, wr_sum, wr_index, wr_sum_out}
  localparam logic [9:0] V_IDLE   = 10'b000_00_00000;
  localparam logic [9:0] V_LOAD   = 10'b010_00_10110;
  localparam logic [9:0] V_WAITV  = 10'b110_00_01010;
  localparam logic [9:0] V_WAITN  = 10'b110_00_00000;
  localparam logic [9:0] V_SCANEQ = 10'b010_11_00110;
  localparam logic [9:0] V_SCANNE = 10'b010_11_00010;
  localparam logic [9:0] V_STOP   = 10'b010_00_00000;
  localparam logic [9:0] V_WRITE  = 10'b010_00_00001;
  localparam logic [9:0] V_DONE   = 10'b011_00_00000;

  typedef logic [9:0] vec_arr_t [16];
  typedef logic [3:0] nib_arr_t [16];

  logic             clock;
  logic             reset_n;
  logic [2:0]       start_v;
  logic [2:0]       valid_v;
  logic [2:0][3:0]  cdata_v;
  logic [2:0][15:0] cypher_v;
  logic [2:0][9:0]  ctl_v;
  logic [2:0][7:0]  sum_out_v;
  int               checks;
  int               errors;
  int               done_count;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NK = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic compared_ready, stop, equal, sl_sum, sl_index, wr_cypher;
    logic wr_compared, wr_sum, wr_index, wr_sum_out, busy, done;
    logic [15:0] cy_r;
    logic [3:0]  cmp_r;
    logic [2:0]  idx_r;
    logic [7:0]  sum_r;
    logic [7:0]  sum_out_r;

    datapath_controller #(.NUM_KEYS(NK)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .start          (start_v[g]),
      .compared_valid (valid_v[g]),
      .compared_ready (compared_ready),
      .stop           (stop),
      .equal          (equal),
      .sl_sum         (sl_sum),
      .sl_index       (sl_index),
      .wr_cypher      (wr_cypher),
      .wr_compared    (wr_compared),
      .wr_sum         (wr_sum),
      .wr_index       (wr_index),
      .wr_sum_out     (wr_sum_out),
      .busy           (busy),
      .done           (done)
    );

    assign stop  = (idx_r > 3'd3);
    assign equal = (cy_r[{idx_r[1:0], 2'b00} +: 4] == cmp_r);

    // Behavioural datapath; it has no reset so sum_out survives an aborted job.
    always @(posedge clock) begin
      if (wr_cypher)   cy_r      <= cypher_v[g];
      if (wr_compared) cmp_r     <= cdata_v[g];
      if (wr_index)    idx_r     <= sl_index ? idx_r + 3'd1 : 3'd0;
      if (wr_sum)      sum_r     <= sl_sum ? sum_r + {4'd0, cmp_r} : 8'd0;
      if (wr_sum_out)  sum_out_r <= sum_r;
    end

    assign ctl_v[g] = {compared_ready, busy, done, sl_sum, sl_index,
                       wr_cypher, wr_compared, wr_sum, wr_index, wr_sum_out};
    assign sum_out_v[g] = sum_out_r;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs for instance g at the falling edge, then let it settle.
  task automatic applyStimulus(input logic [1:0] g, input logic st, input logic cv,
                               input logic [3:0] cd);
    @(negedge clock);
    start_v    = '0;
    valid_v    = '0;
    start_v[g] = st;
    valid_v[g] = cv;
    cdata_v[g] = cd;
    #1;
    if (ctl_v[g][7]) done_count++;
  endtask

  task automatic runTable(input logic [1:0] g, input string name, input int n,
                          input logic [15:0] st, input logic [15:0] cv,
                          input nib_arr_t cd, input vec_arr_t ex);
    for (int c = 0; c < n; c++) begin
      applyStimulus(g, st[c], cv[c], cd[c]);
      checkOutput($sformatf("%s_c%0d", name, c), 32'(ctl_v[g]), 32'(ex[c]));
    end
  endtask

  // Run with compared_valid high until done; lat stays -1 if the budget runs out.
  task automatic runToDone(input logic [1:0] g, input logic [3:0] cd, input int budget,
                           output int lat);
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      applyStimulus(g, 1'b0, 1'b1, cd);
      if (ctl_v[g][7]) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    vec_arr_t ex;
    nib_arr_t cd;
    int       lat;
    checks     = 0;
    errors     = 0;
    done_count = 0;
    reset_n    = 1'b0;
    start_v    = '0;
    valid_v    = '0;
    cdata_v    = '0;
    cypher_v   = '0;

    // Reset state: every output low on all instances.
    #2;
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("reset_ctl_%0d", i), 32'(ctl_v[i]), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // One key, cypher 3A33, compared 3: matches on nibbles 0, 1 and 3.
    cypher_v[0] = 16'h3A33;
    cd = '{default: 4'h3};
    ex = '{0: V_IDLE, 1: V_LOAD, 2: V_WAITV, 3: V_SCANEQ, 4: V_SCANEQ,
           5: V_SCANNE, 6: V_SCANEQ, 7: V_STOP, 8: V_WRITE, 9: V_DONE,
           default: V_IDLE};
    runTable(2'd0, "job1", 11, 16'h0001, 16'hFFFF, cd, ex);
    checkOutput("job1_sum", 32'(sum_out_v[0]), 32'd9);
    checkOutput("job1_done", 32'(done_count), 32'd1);

    // Two keys back to back, cypher 1212, keys 1 then 2.
    cypher_v[1] = 16'h1212;
    cd = '{8: 4'h2, default: 4'h1};
    ex = '{0: V_IDLE, 1: V_LOAD, 2: V_WAITV, 3: V_SCANNE, 4: V_SCANEQ,
           5: V_SCANNE, 6: V_SCANEQ, 7: V_STOP, 8: V_WAITV, 9: V_SCANEQ,
           10: V_SCANNE, 11: V_SCANEQ, 12: V_SCANNE, 13: V_STOP,
           14: V_WRITE, 15: V_DONE, default: V_IDLE};
    runTable(2'd1, "job2", 16, 16'h0001, 16'hFFFF, cd, ex);
    checkOutput("job2_sum", 32'(sum_out_v[1]), 32'd6);
    checkOutput("job2_done", 32'(done_count), 32'd2);

    // compared_valid held low for three WAIT_KEY cycles.
    cypher_v[0] = 16'h5555;
    cd = '{default: 4'h5};
    ex = '{0: V_IDLE, 1: V_LOAD, 2: V_WAITN, 3: V_WAITN, 4: V_WAITN,
           5: V_WAITV, 6: V_SCANEQ, 7: V_SCANEQ, 8: V_SCANEQ, 9: V_SCANEQ,
           10: V_STOP, 11: V_WRITE, 12: V_DONE, default: V_IDLE};
    runTable(2'd0, "stall", 14, 16'h0001, 16'hFFE3, cd, ex);
    checkOutput("stall_sum", 32'(sum_out_v[0]), 32'h14);
    checkOutput("stall_done", 32'(done_count), 32'd3);

    // Reset during the third SCAN cycle, then start on the first edge after release.
    cypher_v[0] = 16'h1111;
    cd = '{default: 4'h1};
    ex = '{0: V_IDLE, 1: V_LOAD, 2: V_WAITV, 3: V_SCANEQ, 4: V_SCANEQ,
           5: V_SCANEQ, default: V_IDLE};
    runTable(2'd0, "abort", 6, 16'h0001, 16'hFFFF, cd, ex);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async", 32'(ctl_v[0]), 32'd0);
    @(negedge clock);
    reset_n    = 1'b1;
    start_v[0] = 1'b1;
    #1;
    checkOutput("rst_idle", 32'(ctl_v[0]), 32'd0);
    checkOutput("rst_sum_kept", 32'(sum_out_v[0]), 32'h14);
    checkOutput("rst_no_done", 32'(done_count), 32'd3);
    applyStimulus(2'd0, 1'b0, 1'b1, 4'h1);
    checkOutput("rst_first_start", 32'(ctl_v[0]), 32'(V_LOAD));
    runToDone(2'd0, 4'h1, 20, lat);
    checkOutput("rst_job_lat", 32'(lat), 32'd8);
    checkOutput("rst_job_sum", 32'(sum_out_v[0]), 32'd4);
    checkOutput("rst_job_done", 32'(done_count), 32'd4);

    // start pulsed during SCAN and during DONE must be ignored.
    cypher_v[0] = 16'h3A33;
    cd = '{default: 4'h3};
    ex = '{0: V_IDLE, 1: V_LOAD, 2: V_WAITV, 3: V_SCANEQ, 4: V_SCANEQ,
           5: V_SCANNE, 6: V_SCANEQ, 7: V_STOP, 8: V_WRITE, 9: V_DONE,
           default: V_IDLE};
    runTable(2'd0, "ignst", 12, 16'h0211, 16'hFFFF, cd, ex);
    checkOutput("ignst_sum", 32'(sum_out_v[0]), 32'd9);
    checkOutput("ignst_done", 32'(done_count), 32'd5);

    // Four keys of F against FFFF: the largest legal sum, done exactly once.
    cypher_v[2] = 16'hFFFF;
    applyStimulus(2'd2, 1'b1, 1'b1, 4'hF);
    checkOutput("max_start", 32'(ctl_v[2]), 32'(V_IDLE));
    runToDone(2'd2, 4'hF, 40, lat);
    checkOutput("max_lat", 32'(lat), 32'd27);
    applyStimulus(2'd2, 1'b0, 1'b1, 4'hF);
    applyStimulus(2'd2, 1'b0, 1'b1, 4'hF);
    checkOutput("max_idle", 32'(ctl_v[2]), 32'(V_IDLE));
    checkOutput("max_sum", 32'(sum_out_v[2]), 32'hF0);
    checkOutput("max_done", 32'(done_count), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
